mulu: RTL

MULU -- requirements
Module: mulu

---
 rtl/mulu.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mulu.sv
// Sequential unsigned fixed-point multiplier: one shift-add step per cycle, WIDTH cycles per product.
// Optional half-up rounding of the fractional cut-off is enabled by defining MULU_ROUND_EN.
module mulu #(
  parameter int WIDTH = 8,
  parameter int FBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             ovf,
  output logic [WIDTH-1:0] val
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] val_q, val_d;

  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] frac_cut;
  logic [WIDTH:0]   rounded;
  logic             round_bit;
  logic             hi_nz;
  logic             ovf_calc;
  logic             last_step;
  logic             unused_prod;

  // The final step's sum feeds the result directly so completion lands on the WIDTH-th edge.
  assign prod      = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign hi_nz     = |prod[PW-1:WIDTH+FBITS];
  assign frac_cut  = prod[WIDTH+FBITS-1:FBITS];
  assign rounded   = {1'b0, frac_cut} + {{WIDTH{1'b0}}, round_bit};
  assign ovf_calc  = hi_nz | rounded[WIDTH];
  assign last_step = (cnt_q == CW'(WIDTH - 1));
  assign unused_prod = ^prod;

`ifdef MULU_ROUND_EN
  if (FBITS > 0) begin : g_round
    assign round_bit = prod[(FBITS > 0) ? FBITS - 1 : 0];
  end else begin : g_trunc
    assign round_bit = 1'b0;
  end
`else
  assign round_bit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    val_d    = val_q;

    if (start) begin
      // A start always wins, including mid-calculation: the old operation is dropped silently.
      state_d  = CALC;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      val_d    = '0;
    end else if (state_q == CALC) begin
      acc_d    = prod;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_step) begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (ovf_calc) begin
          ovf_d   = 1'b1;
          valid_d = 1'b0;
          val_d   = '0;
        end else begin
          ovf_d   = 1'b0;
          valid_d = 1'b1;
          val_d   = rounded[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      val_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      val_q    <= val_d;
    end
  end

  assign busy  = (state_q == CALC);
  assign done  = done_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign val   = val_q;

endmodule
